// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS byte-memory responder.
// State encoding for the loader/run FSM plus bus-width and text-segment defaults.
package mips_mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam logic [7:0] DEF_TEXT_TOP = 8'h40;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mips_mem_array.sv
// Purpose: 2**ADDR_W x DATA_W byte store, one sync write port, one async read port.
// Latency: write lands at the clock edge; read is combinational (0 cycles).
// Backpressure: none, every access completes in its own cycle; contents are never reset.
module mips_mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/mips_mem_responder.sv
// Purpose: byte-memory responder for the multicycle MIPS core with a valid/ready boot loader; MEM_TEXT_PROTECT_EN drops core writes below TEXT_TOP.
// Latency: reads are combinational, writes land at the edge; loader accepts one byte per cycle.
// Backpressure: load_ready is high only in LOAD; the core is held via cpu_hold until the image is loaded.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] TEXT_TOP = ADDR_W'(DEF_TEXT_TOP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] memdata,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   load_count,
    output logic              wr_fault
);

`ifdef MEM_TEXT_PROTECT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              wr_fault_q, wr_fault_d;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_wa;
    logic [DATA_W-1:0] arr_wd;
    logic [DATA_W-1:0] arr_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            load_ptr_q   <= '0;
            load_count_q <= '0;
            wr_fault_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            load_count_q <= load_count_d;
            wr_fault_q   <= wr_fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        load_count_d = load_count_q;
        wr_fault_d   = wr_fault_q;
        arr_we       = 1'b0;
        arr_wa       = adr;
        arr_wd       = writedata;
        load_ready   = 1'b0;
        cpu_hold     = 1'b0;
        memdata      = '0;
        case (state_q)
            ST_LOAD: begin
                load_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (load_valid) begin
                    arr_we       = 1'b1;
                    arr_wa       = load_ptr_q;
                    arr_wd       = load_data;
                    load_ptr_d   = load_ptr_q + ADDR_W'(1);
                    load_count_d = load_count_q + (ADDR_W+1)'(1);
                    // Leaving on the last array slot means the wrapped pointer is never used.
                    if (load_last || (load_ptr_q == PTR_MAX)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (memread) begin
                    memdata = arr_rd;
                end
                if (memwrite) begin
                    if (PROT_EN && (adr < TEXT_TOP)) begin
                        wr_fault_d = 1'b1;
                    end else begin
                        arr_we = 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign load_count = load_count_q;
    assign wr_fault   = wr_fault_q;

    mips_mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk(clk),
        .we (arr_we),
        .wa (arr_wa),
        .wd (arr_wd),
        .ra (adr),
        .rd (arr_rd)
    );

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed self-checking bench for mips_mem_responder: loader, run-time bus, reset and text protection.
module tb_mips_mem_responder;

    logic       clk;
    logic       reset;
    logic       memread;
    logic       memwrite;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic [7:0] memdata;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       cpu_hold;
    logic [8:0] load_count;
    logic       wr_fault;

    int checks = 0;
    int errors = 0;

    mips_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .memdata   (memdata),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_ready(load_ready),
        .cpu_hold  (cpu_hold),
        .load_count(load_count),
        .wr_fault  (wr_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        memread = 1'b1;
        adr     = a;
        #1;
        check(tag, 16'(memdata), 16'(exp));
        tick();
        memread = 1'b0;
    endtask

    task automatic core_write(input logic [7:0] a, input logic [7:0] d);
        memwrite  = 1'b1;
        adr       = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    logic [7:0] t1 [4];
    logic [7:0] d8;

    initial begin
        reset = 1'b0; memread = 1'b0; memwrite = 1'b0; adr = '0; writedata = '0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        t1[0] = 8'h20; t1[1] = 8'h07; t1[2] = 8'h00; t1[3] = 8'h0A;
        #1 reset = 1'b1;
        #2;
        check("rst_hold",   16'(cpu_hold),   16'd1);
        check("rst_ready",  16'(load_ready), 16'd1);
        check("rst_count",  16'(load_count), 16'd0);
        check("rst_fault",  16'(wr_fault),   16'd0);
        check("rst_memdat", 16'(memdata),    16'd0);
        tick();
        reset = 1'b0;
        tick();

        // Four-byte image with load_last on the final byte
        for (int i = 0; i < 4; i++) load_byte(t1[i], i == 3);
        check("t1_count", 16'(load_count), 16'd4);
        check("t1_hold",  16'(cpu_hold),   16'd0);
        check("t1_ready", 16'(load_ready), 16'd0);
        for (int i = 0; i < 4; i++) rd_check("t1_read", 8'(i), t1[i]);
        adr = 8'h00;
        #1 check("t1_noread", 16'(memdata), 16'd0);
        tick();

        // Simultaneous read and write: old byte now, new byte after the edge
        core_write(8'h80, 8'h33);
        memread = 1'b1; memwrite = 1'b1; adr = 8'h80; writedata = 8'h5A;
        #1 check("t3_old", 16'(memdata), 16'h33);
        tick();
        memwrite = 1'b0;
        #1 check("t3_new", 16'(memdata), 16'h5A);
        memread = 1'b0;
        tick();

        // Reset in the middle of a six-byte load restarts at address 0
        pulse_reset();
        for (int i = 0; i < 3; i++) load_byte(8'hC0 + 8'(i), 1'b0);
        check("t5_mid_count", 16'(load_count), 16'd3);
        check("t5_mid_hold",  16'(cpu_hold),   16'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_count", 16'(load_count), 16'd0);
        check("t5_rst_hold",  16'(cpu_hold),   16'd1);
        check("t5_rst_ready", 16'(load_ready), 16'd1);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) load_byte(8'hB0 + 8'(i), i == 5);
        check("t5_count", 16'(load_count), 16'd6);
        check("t5_hold",  16'(cpu_hold),   16'd0);
        for (int i = 0; i < 6; i++) rd_check("t5_read", 8'(i), 8'hB0 + 8'(i));
        rd_check("t5_keep80", 8'h80, 8'h5A);

        // Full 256-byte load without load_last, data equals address
        pulse_reset();
        load_valid = 1'b1;
        load_last  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            load_data = 8'(i);
            if (i == 255) begin
                #1;
                check("t2_pre_count", 16'(load_count), 16'd255);
                check("t2_pre_ready", 16'(load_ready), 16'd1);
            end
            tick();
        end
        load_data = 8'hEE;
        tick();
        load_valid = 1'b0;
        check("t2_count", 16'(load_count), 16'd256);
        check("t2_ready", 16'(load_ready), 16'd0);
        check("t2_hold",  16'(cpu_hold),   16'd0);
        rd_check("t2_readFF", 8'hFF, 8'hFF);
        rd_check("t2_read00", 8'h00, 8'h00);
        rd_check("t2_read80", 8'h80, 8'h80);

        // Core bus is ignored while loading
        pulse_reset();
        memwrite = 1'b1; memread = 1'b1; adr = 8'h10; writedata = 8'hFF;
        #1 check("t4_memdat", 16'(memdata), 16'd0);
        tick();
        memwrite = 1'b0; memread = 1'b0;
        load_byte(8'h00, 1'b1);
        check("t4_count", 16'(load_count), 16'd1);
        rd_check("t4_read10", 8'h10, 8'h10);
        // load_valid is ignored in RUN
        load_byte(8'h99, 1'b1);
        check("run_ign_count", 16'(load_count), 16'd1);
        rd_check("run_ign_mem1", 8'h01, 8'h01);

        // Text-segment protection boundary
        core_write(8'h3F, 8'hA5);
`ifdef MEM_TEXT_PROTECT_EN
        d8 = 8'h3F;
        rd_check("t6_3F", 8'h3F, d8);
        check("t6_fault", 16'(wr_fault), 16'd1);
`else
        d8 = 8'hA5;
        rd_check("t6_3F", 8'h3F, d8);
        check("t6_fault", 16'(wr_fault), 16'd0);
`endif
        core_write(8'h40, 8'h5C);
        rd_check("t6_40", 8'h40, 8'h5C);
`ifdef MEM_TEXT_PROTECT_EN
        check("t6_sticky", 16'(wr_fault), 16'd1);
`else
        check("t6_sticky", 16'(wr_fault), 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
